thin_window_buffer: RTL and testbench

- Stage directly upstream of the ALU in the camera/thinning path.
- Accepts a raster stream of 32-bit packed binary-pixel words (32 pixels per word), one row of IMG_WORDS words at a time.
- Keeps the two previous rows in line memories and presents vertically aligned top/center/bottom words, which drive ALU inputA/inputB/inputC for the THI operation.
- Valid/ready handshake on both sides; output register stage provides backpressure.

---
 rtl/thin_pkg.sv | 21 ++
 rtl/thin_window_buffer_if.sv | 30 +++
 rtl/thin_line_ram.sv | 27 ++
 rtl/thin_window_buffer.sv | 146 ++++++++++++++
 tb/tb_thin_window_buffer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/thin_pkg.sv
// Shared types for the thinning-path window buffer: pixel word, row phase, counter width helper.
package thin_pkg;

  localparam int unsigned DEF_WORD_W    = 32;
  localparam int unsigned DEF_IMG_WORDS = 20;
  localparam int unsigned DEF_IMG_ROWS  = 240;

  typedef logic [DEF_WORD_W-1:0] pix_word_t;

  typedef enum logic [1:0] {
    PRIME0 = 2'd0,
    PRIME1 = 2'd1,
    RUN    = 2'd2
  } row_phase_e;

  // Counter width for a modulo-n index, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/thin_window_buffer_if.sv
// Raster-in / window-out handshake bundle between the pixel source, the window buffer and the ALU issue.
interface thin_window_buffer_if #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned COL_W  = 5
);

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_sof;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_top;
  logic [WORD_W-1:0] out_center;
  logic [WORD_W-1:0] out_bottom;
  logic [COL_W-1:0]  out_col;
  logic              out_eol;
  logic              frame_done;

  modport slave (
    input  in_valid, in_data, in_sof, out_ready,
    output in_ready, out_valid, out_top, out_center, out_bottom, out_col, out_eol, frame_done
  );

  modport master (
    output in_valid, in_data, in_sof, out_ready,
    input  in_ready, out_valid, out_top, out_center, out_bottom, out_col, out_eol, frame_done
  );

endinterface

// File: rtl/thin_line_ram.sv
// One image row of pixel words: single write port, combinational read at the same column.
module thin_line_ram
  import thin_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_IMG_WORDS,
  parameter int unsigned DATA_W = DEF_WORD_W,
  localparam int unsigned AW    = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // Contents are never cleared; row priming overwrites every column before it is read.
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign rdata = mem_q[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

endmodule

// File: rtl/thin_window_buffer.sv
// Two-row line buffer presenting vertically aligned top/center/bottom words to the ALU THI operation.
module thin_window_buffer
  import thin_pkg::*;
#(
  parameter int unsigned WORD_W    = DEF_WORD_W,
  parameter int unsigned IMG_WORDS = DEF_IMG_WORDS,
  parameter int unsigned IMG_ROWS  = DEF_IMG_ROWS
) (
  input  logic                  clk,
  input  logic                  reset,
  thin_window_buffer_if.slave   bus
);

  localparam int unsigned COL_W = cnt_w(IMG_WORDS);
  localparam int unsigned ROW_W = cnt_w(IMG_ROWS);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WORDS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_ROWS - 1);

  row_phase_e        phase_q, phase_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_top_q, out_top_d;
  logic [WORD_W-1:0] out_center_q, out_center_d;
  logic [WORD_W-1:0] out_bottom_q, out_bottom_d;
  logic [COL_W-1:0]  out_col_q, out_col_d;
  logic              out_eol_q, out_eol_d;
  logic              frame_done_q, frame_done_d;

  logic              accept;
  logic              load;
  logic [COL_W-1:0]  wr_col;
  logic [WORD_W-1:0] t_word;
  logic [WORD_W-1:0] m_word;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  // A start-of-frame word always lands in column 0, whatever the counter says.
  assign wr_col       = bus.in_sof ? '0 : col_q;

  // mem0 holds row-2, mem1 holds row-1; each accept shifts the column up by one row.
  thin_line_ram #(.DEPTH(IMG_WORDS), .DATA_W(WORD_W)) u_mem0 (
    .clk   (clk),
    .we    (accept),
    .addr  (wr_col),
    .wdata (m_word),
    .rdata (t_word)
  );

  thin_line_ram #(.DEPTH(IMG_WORDS), .DATA_W(WORD_W)) u_mem1 (
    .clk   (clk),
    .we    (accept),
    .addr  (wr_col),
    .wdata (bus.in_data),
    .rdata (m_word)
  );

  always_comb begin
    phase_d      = phase_q;
    col_d        = col_q;
    row_d        = row_q;
    out_valid_d  = out_valid_q;
    out_top_d    = out_top_q;
    out_center_d = out_center_q;
    out_bottom_d = out_bottom_q;
    out_col_d    = out_col_q;
    out_eol_d    = out_eol_q;
    frame_done_d = 1'b0;
    load         = 1'b0;

    if (accept) begin
      if (bus.in_sof) begin
        col_d   = COL_W'(1);
        row_d   = '0;
        phase_d = PRIME0;
      end else begin
        load = (phase_q == RUN);
        if (col_q == LAST_COL) begin
          col_d = '0;
          row_d = ROW_W'(row_q + ROW_W'(1));
          case (phase_q)
            PRIME0: phase_d = PRIME1;
            PRIME1: phase_d = RUN;
            RUN: begin
              if (row_q == LAST_ROW) begin
                phase_d      = PRIME0;
                row_d        = '0;
                frame_done_d = 1'b1;
              end
            end
            default: phase_d = PRIME0;
          endcase
        end else begin
          col_d = COL_W'(col_q + COL_W'(1));
        end
      end
    end

    // A new window replaces the held one in the same cycle it is consumed.
    if (load) begin
      out_valid_d  = 1'b1;
      out_top_d    = t_word;
      out_center_d = m_word;
      out_bottom_d = bus.in_data;
      out_col_d    = col_q;
      out_eol_d    = (col_q == LAST_COL);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q      <= PRIME0;
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      out_top_q    <= '0;
      out_center_q <= '0;
      out_bottom_q <= '0;
      out_col_q    <= '0;
      out_eol_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      out_top_q    <= out_top_d;
      out_center_q <= out_center_d;
      out_bottom_q <= out_bottom_d;
      out_col_q    <= out_col_d;
      out_eol_q    <= out_eol_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_top    = out_top_q;
  assign bus.out_center = out_center_q;
  assign bus.out_bottom = out_bottom_q;
  assign bus.out_col    = out_col_q;
  assign bus.out_eol    = out_eol_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_thin_window_buffer.sv
// Directed + randomized bench for thin_window_buffer on a 4x4-word image against a frame-array reference.
module tb_thin_window_buffer;
  import thin_pkg::*;

  localparam int unsigned W     = 4;
  localparam int unsigned R     = 4;
  localparam int unsigned COL_W = 2;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  thin_window_buffer_if #(.WORD_W(DEF_WORD_W), .COL_W(COL_W)) bus ();

  thin_window_buffer #(.WORD_W(DEF_WORD_W), .IMG_WORDS(W), .IMG_ROWS(R)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: the current frame as a 2-D array, indexed by position within the frame.
  pix_word_t img [R][W];
  int        m_idx;
  bit        exp_valid, exp_fd, exp_eol;
  pix_word_t exp_top, exp_center, exp_bottom;
  int        exp_col;
  int        win_cnt, fd_cnt;
  bit        acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idx      = 0;
    exp_valid  = 1'b0;
    exp_fd     = 1'b0;
    exp_top    = '0;
    exp_center = '0;
    exp_bottom = '0;
    exp_col    = 0;
    exp_eol    = 1'b0;
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
    chk("frame_done", 32'(bus.frame_done), 32'(exp_fd));
    if (exp_valid) begin
      chk("out_top", bus.out_top, exp_top);
      chk("out_center", bus.out_center, exp_center);
      chk("out_bottom", bus.out_bottom, exp_bottom);
      chk("out_col", 32'(bus.out_col), 32'(exp_col));
      chk("out_eol", 32'(bus.out_eol), 32'(exp_eol));
    end
  endtask

  // One clock: drive, predict from frame position, clock, compare.
  task automatic cycle(input logic v, input pix_word_t d, input logic sof, input logic rdy,
                       output bit accepted);
    int r, c;
    bit load;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_sof    = sof;
    bus.out_ready = rdy;
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(!exp_valid || rdy));
    if (bus.out_valid && rdy) win_cnt++;
    accepted = v && (!exp_valid || rdy);
    load   = 1'b0;
    exp_fd = 1'b0;
    if (accepted) begin
      if (sof) m_idx = 0;
      r = m_idx / W;
      c = m_idx % W;
      img[r][c] = d;
      if (r >= 2) begin
        load       = 1'b1;
        exp_top    = img[r-2][c];
        exp_center = img[r-1][c];
        exp_bottom = d;
        exp_col    = c;
        exp_eol    = (c == W - 1);
      end
      m_idx++;
      if (m_idx == W * R) begin
        m_idx  = 0;
        exp_fd = 1'b1;
      end
    end
    if (load) exp_valid = 1'b1;
    else if (exp_valid && rdy) exp_valid = 1'b0;
    @(posedge clk);
    #1;
    if (bus.frame_done) fd_cnt++;
    check_outputs();
  endtask

  // Push n accepted words; data is base + 0xRC of the frame position, or random.
  task automatic feed(input int n, input pix_word_t base, input bit rnd_data, input bit gaps,
                      input bit rnd_rdy);
    int done  = 0;
    int guard = 0;
    bit a;
    while (done < n && guard < 20 * n + 50) begin
      logic      v, rdy;
      pix_word_t d;
      v   = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      rdy = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      d   = rnd_data ? pix_word_t'($urandom)
                     : base + pix_word_t'((m_idx / W) * 16 + (m_idx % W));
      cycle(v, d, 1'b0, rdy, a);
      if (a) done++;
      guard++;
    end
    chk("feed_budget", 32'(done), 32'(n));
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sof    = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    win_cnt = 0;
    fd_cnt  = 0;

    #8;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_top", bus.out_top, 32'd0);
    chk("rst_out_center", bus.out_center, 32'd0);
    chk("rst_out_bottom", bus.out_bottom, 32'd0);
    chk("rst_out_col", 32'(bus.out_col), 32'd0);
    chk("rst_out_eol", 32'(bus.out_eol), 32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    #4;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic fill, first window right after 0x20 is accepted.
    feed(9, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("first_valid", 32'(bus.out_valid), 32'd1);
    chk("first_top", bus.out_top, 32'h00);
    chk("first_center", bus.out_center, 32'h10);
    chk("first_bottom", bus.out_bottom, 32'h20);
    chk("first_col", 32'(bus.out_col), 32'd0);
    feed(7, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("last_top", bus.out_top, 32'h13);
    chk("last_center", bus.out_center, 32'h23);
    chk("last_bottom", bus.out_bottom, 32'h33);
    chk("last_eol", 32'(bus.out_eol), 32'd1);
    chk("last_frame_done", 32'(bus.frame_done), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b1, acc);
    chk("basic_windows", 32'(win_cnt), 32'd8);
    chk("basic_fd_count", 32'(fd_cnt), 32'd1);

    // Second frame with backpressure on its first window.
    feed(9, 32'h100, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h121, 1'b0, 1'b0, acc);
      chk("bp_no_accept", 32'(acc), 32'd0);
    end
    chk("bp_hold_top", bus.out_top, 32'h100);
    chk("bp_hold_center", bus.out_center, 32'h110);
    chk("bp_hold_bottom", bus.out_bottom, 32'h120);
    cycle(1'b1, 32'h121, 1'b0, 1'b1, acc);
    chk("bp_next_top", bus.out_top, 32'h101);
    chk("bp_next_center", bus.out_center, 32'h111);
    chk("bp_next_bottom", bus.out_bottom, 32'h121);
    chk("bp_next_col", 32'(bus.out_col), 32'd1);
    feed(6, 32'h100, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, acc);
    chk("two_frame_windows", 32'(win_cnt), 32'd16);
    chk("two_frame_fd_count", 32'(fd_cnt), 32'd2);

    // Random input bubbles, then bubbles plus random downstream stalls.
    win_cnt = 0;
    fd_cnt  = 0;
    feed(16, 32'h200, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, acc);
    chk("bubble_windows", 32'(win_cnt), 32'd8);
    chk("bubble_fd_count", 32'(fd_cnt), 32'd1);
    feed(16, 32'h0, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1, acc);
    cycle(1'b0, '0, 1'b0, 1'b1, acc);
    chk("stall_windows", 32'(win_cnt), 32'd16);
    chk("stall_fd_count", 32'(fd_cnt), 32'd2);

    // Mid-frame sof after row 2 col 1.
    fd_cnt = 0;
    feed(10, 32'h300, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hA0, 1'b1, 1'b1, acc);
    chk("sof_accepted", 32'(acc), 32'd1);
    win_cnt = 0;
    feed(7, 32'hA0, 1'b0, 1'b0, 1'b0);
    chk("sof_prime_no_window", 32'(win_cnt), 32'd0);
    cycle(1'b1, 32'hC0, 1'b0, 1'b1, acc);
    chk("sof_first_top", bus.out_top, 32'hA0);
    chk("sof_first_center", bus.out_center, 32'hB0);
    chk("sof_first_bottom", bus.out_bottom, 32'hC0);
    feed(7, 32'hA0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, acc);
    chk("sof_windows", 32'(win_cnt), 32'd8);
    chk("sof_fd_count", 32'(fd_cnt), 32'd1);

    // Async reset while a RUN window is pending.
    feed(9, 32'h400, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, acc);
    chk("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_out_top", bus.out_top, 32'd0);
    chk("async_in_ready", 32'(bus.in_ready), 32'd1);
    #3;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    win_cnt = 0;
    fd_cnt  = 0;
    feed(8, 32'h500, 1'b0, 1'b0, 1'b0);
    chk("post_reset_no_window", 32'(win_cnt), 32'd0);
    feed(1, 32'h500, 1'b0, 1'b0, 1'b0);
    chk("post_reset_top", bus.out_top, 32'h500);
    chk("post_reset_bottom", bus.out_bottom, 32'h520);
    feed(7, 32'h500, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, acc);
    chk("post_reset_windows", 32'(win_cnt), 32'd8);
    chk("post_reset_fd_count", 32'(fd_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
